// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive side of a 4:1 time-multiplexed link.
//
// Slots of the serial stream carry channels a, b, c, d in order; sync marks
// the slot-0 sample. Slots 0..2 are collected into shadow registers and all
// four channel outputs are updated together when slot 3 arrives.
//
// Parameters:
//   W            data width of each channel and of din
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   din [W]      serial sample for the current slot (valid when en=1)
//   en           sample strobe
//   sync         frame marker, high with the slot-0 sample
//   a,b,c,d [W]  registered channel outputs
//   slot [2]     slot index expected for the next accepted sample
//   locked       high while aligned to the frame
//   frame_valid  one-cycle pulse after a..d were updated
// Optional (macro TDM_DEMUX_ERR_EN):
//   sync_err     one-cycle pulse on an early or missing marker
//   err_cnt [8]  saturating count of marker errors
module tdm_demux4 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic         sync,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         frame_valid
`ifdef TDM_DEMUX_ERR_EN
  ,
  output logic         sync_err,
  output logic [7:0]   err_cnt
`endif
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [1:0]     slot_q, slot_d;
  logic [W-1:0]   sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic           fv_q, fv_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOCKED;
      slot_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    if (en) begin
      case (state_q)
        UNLOCKED: begin
          if (sync) begin
            sh0_d   = din;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // Normal start or early marker: either way restart the frame here.
            sh0_d  = din;
            slot_d = 2'd1;
          end else begin
            case (slot_q)
              2'd0: state_d = UNLOCKED;   // missing marker
              2'd1: begin
                sh1_d  = din;
                slot_d = 2'd2;
              end
              2'd2: begin
                sh2_d  = din;
                slot_d = 2'd3;
              end
              2'd3: begin
                a_d    = sh0_q;
                b_d    = sh1_q;
                c_d    = sh2_q;
                d_d    = din;
                fv_d   = 1'b1;
                slot_d = 2'd0;
              end
            endcase
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // Outputs
  always_comb begin
    a           = a_q;
    b           = b_q;
    c           = c_q;
    d           = d_q;
    slot        = slot_q;
    locked      = (state_q == LOCKED);
    frame_valid = fv_q;
  end

`ifdef TDM_DEMUX_ERR_EN
  logic       err_ev;
  logic       sync_err_q, sync_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Early marker (sync on slot 1..3) or missing marker (no sync on slot 0).
  always_comb begin
    err_ev = en && (state_q == LOCKED) && (sync ? (slot_q != 2'd0) : (slot_q == 2'd0));
    sync_err_d = err_ev;
    err_cnt_d  = err_cnt_q;
    if (err_ev && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      sync_err_q <= sync_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    sync_err = sync_err_q;
    err_cnt  = err_cnt_q;
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en1, sync1, en4, sync4;
  logic [0:0] din1;
  logic [3:0] din4;
  logic [0:0] a1, b1, c1, d1;
  logic [3:0] a4, b4, c4, d4;
  logic [1:0] slot1, slot4;
  logic       locked1, locked4, fv1, fv4;
`ifdef TDM_DEMUX_ERR_EN
  logic       serr1, serr4;
  logic [7:0] ecnt1, ecnt4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.W(1)) u1 (
    .clk(clk), .reset(reset), .din(din1), .en(en1), .sync(sync1),
    .a(a1), .b(b1), .c(c1), .d(d1), .slot(slot1), .locked(locked1),
    .frame_valid(fv1)
`ifdef TDM_DEMUX_ERR_EN
    , .sync_err(serr1), .err_cnt(ecnt1)
`endif
  );

  tdm_demux4 #(.W(4)) u4 (
    .clk(clk), .reset(reset), .din(din4), .en(en4), .sync(sync4),
    .a(a4), .b(b4), .c(c4), .d(d4), .slot(slot4), .locked(locked4),
    .frame_valid(fv4)
`ifdef TDM_DEMUX_ERR_EN
    , .sync_err(serr4), .err_cnt(ecnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one W=1 sample, clock it, sample outputs 1 time unit later.
  task automatic step1(input logic e, input logic s, input logic dv);
    en1 = e; sync1 = s; din1 = dv;
    @(posedge clk); #1;
  endtask

  task automatic step4(input logic e, input logic s, input logic [3:0] dv);
    en4 = e; sync4 = s; din4 = dv;
    @(posedge clk); #1;
  endtask

  task automatic chk_abcd1(input string tag, input logic [3:0] exp_abcd);
    check(tag, {28'd0, a1, b1, c1, d1}, {28'd0, exp_abcd});
  endtask

  initial begin
    reset = 1'b1;
    en1 = 0; sync1 = 0; din1 = 0;
    en4 = 0; sync4 = 0; din4 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state
    chk_abcd1("rst_abcd", 4'b0000);
    check("rst_slot", slot1, 0);
    check("rst_locked", locked1, 0);
    check("rst_fv", fv1, 0);
    check("rst_abcd4", {a4, b4, c4, d4}, 0);
`ifdef TDM_DEMUX_ERR_EN
    check("rst_serr", serr1, 0);
    check("rst_ecnt", ecnt1, 0);
`endif

    // Test 1: frame 0,1,1,1 back to back
    step1(1, 1, 0);
    check("t1_slot1", slot1, 1);
    check("t1_locked", locked1, 1);
    step1(1, 0, 1);
    check("t1_slot2", slot1, 2);
    step1(1, 0, 1);
    check("t1_slot3", slot1, 3);
    check("t1_fv_pre", fv1, 0);
    step1(1, 0, 1);
    chk_abcd1("t1_abcd", 4'b0111);
    check("t1_fv", fv1, 1);
    check("t1_slot0", slot1, 0);
    check("t1_locked_end", locked1, 1);
    step1(0, 0, 0);
    check("t1_fv_drop", fv1, 0);
    chk_abcd1("t1_hold", 4'b0111);

    // Test 2: same frame with two idle cycles between samples
    step1(1, 1, 0);
    check("t2_slot1", slot1, 1);
    step1(0, 0, 1); step1(0, 1, 1);
    check("t2_idle_slot1", slot1, 1);
    step1(1, 0, 1);
    check("t2_slot2", slot1, 2);
    step1(0, 0, 0); step1(0, 0, 0);
    check("t2_idle_slot2", slot1, 2);
    step1(1, 0, 1);
    check("t2_slot3", slot1, 3);
    step1(0, 0, 0);
    check("t2_idle_fv", fv1, 0);
    step1(0, 0, 0);
    check("t2_idle_slot3", slot1, 3);
    step1(1, 0, 1);
    chk_abcd1("t2_abcd", 4'b0111);
    check("t2_fv", fv1, 1);
    check("t2_slot0", slot1, 0);

    // Test 3: early marker at slot 2
    step1(1, 1, 1);
    step1(1, 0, 0);
    check("t3_slot2", slot1, 2);
    step1(1, 1, 1);
    check("t3_early_fv", fv1, 0);
    check("t3_early_slot", slot1, 1);
    check("t3_early_locked", locked1, 1);
    chk_abcd1("t3_early_hold", 4'b0111);
`ifdef TDM_DEMUX_ERR_EN
    check("t3_serr", serr1, 1);
    check("t3_ecnt", ecnt1, 1);
`endif
    step1(1, 0, 0);
`ifdef TDM_DEMUX_ERR_EN
    check("t3_serr_drop", serr1, 0);
`endif
    step1(1, 0, 0);
    check("t3_fv_pre", fv1, 0);
    step1(1, 0, 1);
    chk_abcd1("t3_abcd", 4'b1001);
    check("t3_fv", fv1, 1);

    // Test 4: missing marker at slot 0
    step1(1, 0, 1);
    check("t4_locked", locked1, 0);
    check("t4_slot", slot1, 0);
    check("t4_fv", fv1, 0);
`ifdef TDM_DEMUX_ERR_EN
    check("t4_serr", serr1, 1);
    check("t4_ecnt", ecnt1, 2);
`endif
    for (int i = 0; i < 3; i++) begin
      step1(1, 0, 0);
      check("t4_ign_slot", slot1, 0);
      check("t4_ign_fv", fv1, 0);
      check("t4_ign_locked", locked1, 0);
    end
    chk_abcd1("t4_hold", 4'b1001);
    step1(1, 1, 1);
    check("t4_relock", locked1, 1);
    check("t4_relock_slot", slot1, 1);

    // Test 5: reset mid-frame
    step1(1, 0, 1);
    check("t5_slot2", slot1, 2);
    reset = 1'b1;
    step1(1, 0, 1);
    reset = 1'b0;
    chk_abcd1("t5_rst_abcd", 4'b0000);
    check("t5_rst_slot", slot1, 0);
    check("t5_rst_locked", locked1, 0);
    check("t5_rst_fv", fv1, 0);
`ifdef TDM_DEMUX_ERR_EN
    check("t5_rst_ecnt", ecnt1, 0);
`endif
    step1(1, 1, 1);
    step1(1, 0, 1);
    step1(1, 0, 0);
    chk_abcd1("t5_pre", 4'b0000);
    step1(1, 0, 1);
    chk_abcd1("t5_abcd", 4'b1101);
    check("t5_fv", fv1, 1);
    step1(0, 0, 0);

    // Test 6: W=4, three back-to-back frames
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        step4(1, (s == 0), 4'(4 * f + s + 1));
        check("t6_fv", fv4, (s == 3));
        check("t6_slot", slot4, (s + 1) % 4);
      end
      check("t6_a", a4, 4 * f + 1);
      check("t6_b", b4, 4 * f + 2);
      check("t6_c", c4, 4 * f + 3);
      check("t6_d", d4, 4 * f + 4);
    end
    step4(0, 0, 0);
    check("t6_fv_drop", fv4, 0);
    check("t6_hold_d", d4, 4'hC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive side of the 4:1 time-multiplexed link: takes a serial stream whose slots carry channels a, b, c, d in order.
- Tracks slot position using a frame-sync marker.
- Collects one full frame into shadow registers, then updates four registered channel outputs together.
- Sits after the 4:1 multiplexer path and restores the four parallel channels for downstream logic.

Parameters:
- W, 1, data width of each channel and of the serial input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  W  serial TDM data for the current slot.
- en  input  1  sample strobe; din and sync are valid only when en=1.
- sync  input  1  frame marker; high together with the slot-0 (channel a) sample.
- a  output  W  channel 0, registered.
- b  output  W  channel 1, registered.
- c  output  W  channel 2, registered.
- d  output  W  channel 3, registered.
- slot  output  2  slot index expected for the next accepted sample.
- locked  output  1  high while aligned to the frame.
- frame_valid  output  1  one-cycle pulse when a, b, c, d were just updated.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), fixed.
- Reset values: a=b=c=d=0, slot=0, locked=0, frame_valid=0, shadow registers=0. Reset has priority over every other input. A reset mid-frame discards the partial frame.
- en=0: no state change; frame_valid=0; a..d hold.
- frame_valid defaults to 0 every cycle and is set only as described below.
- State machine has two states: UNLOCKED and LOCKED. The locked output is 1 exactly when in LOCKED.
- UNLOCKED, en=1, sync=1: shadow0<=din; slot<=1; go to LOCKED.
- UNLOCKED, en=1, sync=0: sample ignored; slot stays 0.
- LOCKED, en=1, sync=0, slot in 1..2: shadow[slot]<=din; slot<=slot+1.
- LOCKED, en=1, sync=0, slot=3: a<=shadow0, b<=shadow1, c<=shadow2, d<=din, all on the same edge; frame_valid<=1 for that one cycle; slot wraps to 0.
- LOCKED, en=1, slot=0, sync=1: normal frame start; shadow0<=din; slot<=1.
- LOCKED, en=1, slot=0, sync=0 (missing marker): sample discarded; go to UNLOCKED; slot stays 0; a..d hold.
- LOCKED, en=1, sync=1, slot!=0 (early marker, misalignment): partial frame discarded; shadow0<=din; slot<=1; stay LOCKED; a..d hold; no frame_valid.
- Latency: a..d and frame_valid change on the edge that accepts the slot-3 sample and are visible in the following cycle. Back-to-back frames with en held high give one frame_valid every 4 cycles.
- a..d change only on a complete, aligned frame or on reset.

Optional Feature:
- Macro: TDM_DEMUX_ERR_EN.
- Defined: adds output sync_err (1 bit) and output err_cnt (8 bits).
- sync_err pulses for one cycle on each early-marker or missing-marker event.
- err_cnt increments on each such event and saturates at 255.
- Reset clears both sync_err and err_cnt.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. W=1, reset, then en=1 for 4 cycles with din=0,1,1,1 and sync=1 on the first sample -> a=0, b=1, c=1, d=1; frame_valid high exactly one cycle; locked=1; slot=0.
2. Same frame as test 1 with en=0 for 2 cycles between each sample -> same outputs; a..d unchanged until the 4th accepted sample; slot steps 1,2,3,0 only on en cycles.
3. After a valid frame (a..d=0,1,1,1), start a new frame 1,0 then assert sync on slot 2 with din=1, followed by 0,0,1 -> no frame_valid at the early marker; next outputs a=1, b=0, c=0, d=1; sync_err pulses once and err_cnt=1 with the macro defined.
4. Locked and at slot 0, en=1 with sync=0 -> locked=0; then 3 further samples are ignored (slot stays 0, no frame_valid) until the next sync=1 relocks.
5. Reset asserted after 2 samples of a frame -> next cycle all outputs 0, locked=0; a following full frame 1,1,0,1 gives a=1, b=1, c=0, d=1.
6. W=4, en held high, 3 consecutive frames (1,2,3,4), (5,6,7,8), (9,A,B,C) -> frame_valid on cycles 4, 8, 12; outputs match each frame in turn.
